// File: rtl/exec_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// exec_sequencer_pkg : shared states, branch/memory-select encodings, widths
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exec_sequencer_pkg;

  localparam int OPCODE_W = 5;
  localparam int INSTR_W  = 17;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_NEXT  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [1:0] BS_INC   = 2'b00;
  localparam logic [1:0] BS_ZCOND = 2'b01;
  localparam logic [1:0] BS_REG   = 2'b10;
  localparam logic [1:0] BS_JMP   = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IN  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/exec_sequencer_if.sv
// ---------------------------------------------------------------------------
// exec_sequencer_if : instruction-fetch and data-memory handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface exec_sequencer_if #(
  parameter int PC_W = 8
);
  import exec_sequencer_pkg::*;

  logic               imem_req;
  logic               imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_ack;
  logic               dmem_we;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

`default_nettype wire

// File: rtl/exec_sequencer_pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel : combinational next-pc selection from branch select and flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_next_sel
  import exec_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] tgt_i,
  input  logic [1:0]      bs_i,
  input  logic            ps_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] pc_inc;

  // Increment wraps naturally at 2^PC_W.
  assign pc_inc = pc_i + PC_W'(1);

  always_comb begin
    pc_next_o = pc_inc;
    unique case (bs_i)
      BS_INC:   pc_next_o = pc_inc;
      BS_ZCOND: pc_next_o = zero_i ? tgt_i : pc_inc;
      BS_REG:   pc_next_o = tgt_i;
      BS_JMP:   pc_next_o = (ps_i && zero_i) ? pc_inc : tgt_i;
      default:  pc_next_o = pc_inc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer : fetch/execute/memory/next-pc control FSM with mem timeout
// Optional retired-instruction counter: EXEC_SEQUENCER_PERF_CNT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int MEM_TO = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  exec_sequencer_if.master   mem_bus,
  output logic [INSTR_W-1:0] ir_o,
  input  logic [1:0]         bs_i,
  input  logic               ps_i,
  input  logic               rw_i,
  input  logic               mw_i,
  input  logic [1:0]         md_i,
  input  logic               zero_i,
  input  logic [PC_W-1:0]    tgt_i,
  output logic               rf_we_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               fault_o
`ifdef EXEC_SEQUENCER_PERF_CNT_EN
  ,
  output logic [15:0]        retired_cnt_o
`endif
);

  localparam int             CNT_W     = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(MEM_TO - 1);

  state_e             state_q, state_d;
  logic               run_q;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_next;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic               fault_q, fault_d;
  logic [1:0]         bs_q;
  logic               ps_q, zero_q;
  logic [PC_W-1:0]    tgt_q;
  logic               imem_req, dmem_req, dmem_we, rf_we, mem_op;

  assign mem_op = mw_i | (md_i != MD_ALU);

  pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
    .pc_i      (pc_q),
    .tgt_i     (tgt_q),
    .bs_i      (bs_q),
    .ps_i      (ps_q),
    .zero_i    (zero_q),
    .pc_next_o (pc_next)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    to_cnt_d = '0;
    fault_d  = fault_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    unique case (state_q)
      // run_q holds off the first fetch until one edge after reset release.
      ST_FETCH: begin
        imem_req = run_q;
        if (run_q && mem_bus.imem_ack) begin
          ir_d    = mem_bus.imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (mem_op) begin
          state_d = ST_MEM;
        end else begin
          rf_we   = rw_i;
          state_d = ST_NEXT;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw_i;
        if (mem_bus.dmem_ack) begin
          rf_we   = rw_i;
          state_d = ST_NEXT;
        end else if (to_cnt_q == C_TO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        pc_d    = pc_next;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      run_q    <= 1'b0;
      ir_q     <= '0;
      pc_q     <= '0;
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
      bs_q     <= '0;
      ps_q     <= 1'b0;
      zero_q   <= 1'b0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
      // Branch inputs are captured as EXEC ends so NEXT never sees later changes.
      if (state_q == ST_EXEC) begin
        bs_q   <= bs_i;
        ps_q   <= ps_i;
        zero_q <= zero_i;
        tgt_q  <= tgt_i;
      end
    end
  end

`ifdef EXEC_SEQUENCER_PERF_CNT_EN
  logic [15:0] retired_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
    end else if ((state_q == ST_NEXT) && (retired_cnt_q != 16'hFFFF)) begin
      retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  assign retired_cnt_o = retired_cnt_q;
`endif

  assign mem_bus.imem_req  = imem_req;
  assign mem_bus.imem_addr = pc_q;
  assign mem_bus.dmem_req  = dmem_req;
  assign mem_bus.dmem_we   = dmem_we;
  assign ir_o              = ir_q;
  assign rf_we_o           = rf_we;
  assign pc_o              = pc_q;
  assign fault_o           = fault_q;

endmodule

`default_nettype wire

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The module SHALL have parameter PC_W, default 8, meaning the program counter width in bits.
REQ-002 The module SHALL have parameter MEM_TO, default 15, meaning the data-memory wait timeout in cycles.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req / imem_ack  output / input  1 / 1  instruction fetch handshake.
REQ-006 imem_addr  output  PC_W  fetch address, equal to pc.
REQ-007 imem_rdata  input  17  fetched instruction word.
REQ-008 ir  output  17  latched instruction presented to the decoder.
REQ-009 bs, ps, rw, mw, md  input  2, 1, 1, 1, 2  decoded controls.
REQ-010 zero  input  1  datapath zero flag.
REQ-011 tgt  input  PC_W  branch or jump target from the datapath.
REQ-012 rf_we  output  1  gated register-file write strobe.
REQ-013 dmem_req / dmem_ack  output / input  1 / 1  data-memory or IO handshake.
REQ-014 dmem_we  output  1  data-memory write qualifier.
REQ-015 pc  output  PC_W  program counter.
REQ-016 fault  output  1  sticky flag set on data-memory timeout.

Function
REQ-017 The FSM SHALL have the states FETCH, EXEC, MEM, NEXT and HALT.
- FETCH: imem_req=1. On imem_ack, ir<=imem_rdata and the FSM goes to EXEC; otherwise it stays in FETCH.
REQ-018 EXEC SHALL last exactly one cycle.
- If mw=1 or md!=00, go to MEM.
- Otherwise rf_we=rw for this cycle, then go to NEXT.
REQ-019 MEM SHALL hold dmem_req=1, with dmem_we=mw, until dmem_ack.
- On dmem_ack: rf_we=rw for that single cycle, then go to NEXT.
REQ-020 In MEM, if dmem_ack has not arrived after MEM_TO cycles, the FSM SHALL set fault, suppress rf_we and go to HALT.
REQ-021 NEXT SHALL update pc for one cycle and then go to FETCH:
- bs=00: pc+1.
- bs=01: tgt if zero=1, else pc+1.
- bs=10: tgt.
- bs=11: if ps=0, tgt; if ps=1, tgt when zero=0, else pc+1.
REQ-022 pc arithmetic SHALL be modulo 2^PC_W; all-ones+1 wraps to 0 with no flag.
REQ-023 The bs, ps, zero and tgt values used in NEXT SHALL be sampled at the end of EXEC (registered), not re-read in NEXT.
REQ-024 The instruction word ir==0 (NOP) SHALL pass through FETCH, EXEC and NEXT with rf_we=0 and no dmem_req.
REQ-025 imem_req SHALL be low in every state except FETCH; dmem_req SHALL be low in every state except MEM.
REQ-026 rf_we SHALL never be high for more than one cycle per instruction.
REQ-027 HALT SHALL be terminal: all request and strobe outputs are 0 and pc is frozen, until reset.
REQ-028 An imem_ack arriving outside FETCH, or a dmem_ack arriving outside MEM, SHALL be ignored.
REQ-029 Minimum latency SHALL be 3 cycles per non-memory instruction (FETCH with immediate ack, EXEC, NEXT).

Reset
REQ-030 rst_n low SHALL asynchronously force:
- state=FETCH, pc=0, ir=0, fault=0;
- rf_we=0, imem_req=0, dmem_req=0, dmem_we=0;
- the timeout counter to 0.
REQ-031 imem_req SHALL first assert on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-MEM or mid-FETCH SHALL abandon the transaction with no write and no pc update.

Configuration
REQ-033 The macro EXEC_SEQUENCER_PERF_CNT_EN SHALL control the performance counter.
- Defined: a 16-bit output retired_cnt counts NEXT states, reset to 0 and saturating at 0xFFFF.
- Undefined: the port does not exist and no counter logic is built.

Structure
REQ-034 A shared package SHALL hold:
- the state enumeration;
- the BS encodings (BS_INC, BS_ZCOND, BS_REG, BS_JMP);
- the MD encodings (MD_ALU, MD_MEM, MD_IN);
- the opcode width of 5 and the instruction width of 17.
REQ-035 The pc next-value selection SHALL be a sub-module, pc_next_sel (combinational: pc, tgt, bs, ps, zero -> next pc).

Verification
REQ-036 ADD (rw=1, bs=00) at pc=3 with immediate acks -> rf_we pulses once in EXEC, pc=4 three cycles after the FETCH start.
REQ-037 LD (md=01) with dmem_ack delayed 4 cycles -> dmem_req high for 5 cycles, rf_we on the ack cycle only, pc+1.
REQ-038 bs=01 with zero=1, tgt=0x20 -> pc=0x20; same with zero=0 -> pc+1.
REQ-039 bs=11, ps=1, zero=0, tgt=0x40 -> pc=0x40; with zero=1 -> pc+1.
REQ-040 ST (mw=1) with no dmem_ack for 15 cycles -> fault=1, HALT, no further imem_req; rst_n pulse -> pc=0, fault=0.
REQ-041 pc=0xFF, bs=00 -> pc=0x00; rst_n asserted during a MEM wait -> dmem_req drops immediately and rf_we is never asserted.
